// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo responder: TX handshake states and
// default widths.
package uart_pkg;

  localparam int         DATA_WIDTH  = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_echo_ctrl_if.sv
// Byte-level links between the echo controller and uart_rx/uart_tx.
// The controller takes the master side; the UART pair takes the slave side.
interface uart_echo_ctrl_if #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_ready;
  logic                  rx_error;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_send;
  logic                  tx_ready;

  modport master (
    input  rx_data, rx_ready, rx_error, tx_ready,
    output tx_data, tx_send
  );

  modport slave (
    output rx_data, rx_ready, rx_error, tx_ready,
    input  tx_data, tx_send
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write into a full FIFO is
// accepted when a read frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_AW:0]      count
);

  localparam int               DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH; count carries the extra bit for "full".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo responder: queues bytes completed by uart_rx and hands them back to
// uart_tx in order, dropping errored bytes and keeping sticky debug status.
module uart_echo_ctrl #(
  parameter int DATA_WIDTH    = uart_pkg::DATA_WIDTH,
  parameter int FIFO_AW       = 4,
  parameter bit DROP_ON_ERROR = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_echo_ctrl_if.master    bus,
  input  logic                clear_status,
  output logic [FIFO_AW:0]    fifo_count,
  output logic                overflow,
  output logic [7:0]          err_count
);

  import uart_pkg::*;

  logic                  rx_ready_q;
  logic                  rx_rise, err_evt, rx_good, pop, ovf_evt;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_send_q;
  tx_state_e             state;

  assign rx_rise = bus.rx_ready & ~rx_ready_q;
  assign err_evt = rx_rise & bus.rx_error;
  assign rx_good = rx_rise & (~bus.rx_error | ~DROP_ON_ERROR);
  assign pop     = (state == IDLE) & ~fifo_empty & bus.tx_ready;
  assign ovf_evt = rx_good & fifo_full & ~pop;

  assign bus.tx_send = tx_send_q;
  assign bus.tx_data = tx_data_q;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rx_good),
    .wr_data (bus.rx_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Reset to 1 so a receiver already flagging ready at release is not a new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_ready_q <= 1'b1;
    else        rx_ready_q <= bus.rx_ready;
  end

  // A clear coinciding with an event leaves just that event recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else if (clear_status) begin
      overflow  <= ovf_evt;
      err_count <= err_evt ? 8'd1 : 8'd0;
    end else begin
      if (ovf_evt) overflow <= 1'b1;
      if (err_evt && (err_count != ERR_CNT_MAX)) err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data_q <= fifo_head;
            tx_send_q <= 1'b1;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!bus.tx_ready) begin
            tx_send_q <= 1'b0;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_ready) state <= IDLE;
        end
        default: begin
          tx_send_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench for uart_echo_ctrl: directed scenarios plus a random
// phase, compared every cycle against a queue-based behavioural model.
module tb_uart_echo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam bit DROP  = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_status = 1'b0;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic [7:0]    err_count;

  logic          manual_ready = 1'b1;
  logic          agent_on = 1'b0;
  logic          agent_ready = 1'b1;
  int            agent_dly = 0;
  int            agent_busy = 0;
  logic          chk_on = 1'b0;

  uart_echo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  assign bus.tx_ready = agent_on ? agent_ready : manual_ready;

  uart_echo_ctrl #(
    .DATA_WIDTH    (DW),
    .FIFO_AW       (AW),
    .DROP_ON_ERROR (DROP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .clear_status (clear_status),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: a byte queue plus the transmitter handshake phase.
  logic [DW-1:0] m_q [$];
  logic          m_send = 1'b0;
  logic          m_wait_high = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_ovf = 1'b0;
  logic [7:0]    m_err = '0;
  logic          m_prev_ready = 1'b1;
  logic          m_rise;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_send = 1'b0;
      m_wait_high = 1'b0;
      m_data = '0;
      m_ovf = 1'b0;
      m_err = '0;
      m_prev_ready = 1'b1;
    end else begin
      m_rise = bus.rx_ready && !m_prev_ready;
      m_prev_ready = bus.rx_ready;
      if (m_send) begin
        if (!bus.tx_ready) begin
          m_send = 1'b0;
          m_wait_high = 1'b1;
        end
      end else if (m_wait_high) begin
        if (bus.tx_ready) m_wait_high = 1'b0;
      end else if (m_q.size() != 0 && bus.tx_ready) begin
        m_data = m_q.pop_front();
        m_send = 1'b1;
      end
      if (clear_status) begin
        m_ovf = 1'b0;
        m_err = '0;
      end
      if (m_rise && bus.rx_error && m_err != 8'hFF) m_err = m_err + 8'd1;
      if (m_rise && (!bus.rx_error || !DROP)) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.rx_data);
        else m_ovf = 1'b1;
      end
    end
  end

  // Reactive transmitter: acknowledges a send after a short delay, stays busy a while.
  initial forever begin
    @(negedge clk);
    if (!agent_on || !rst_n) begin
      agent_ready = 1'b1;
      agent_dly = int'($urandom_range(0, 2));
      agent_busy = 0;
    end else if (agent_ready) begin
      if (bus.tx_send) begin
        if (agent_dly == 0) begin
          agent_ready = 1'b0;
          agent_busy = int'($urandom_range(0, 4));
        end else begin
          agent_dly--;
        end
      end
    end else if (agent_busy == 0) begin
      agent_ready = 1'b1;
      agent_dly = int'($urandom_range(0, 2));
    end else begin
      agent_busy--;
    end
  end

  // Literal expectations are posted by the stimulus and evaluated by the compare process.
  string         req_name [64];
  logic [31:0]   req_act  [64];
  logic [31:0]   req_exp  [64];
  int            lit_seq = 0;
  int            lit_done = 0;

  int            total_cnt = 0;
  int            pass_cnt = 0;
  logic [DW-1:0] echo_log [$];
  logic          prev_send = 1'b0;
  logic [22:0]   exp_v, act_v;

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      exp_v = {m_send, m_data, 5'(m_q.size()), m_ovf, m_err};
      act_v = {bus.tx_send, bus.tx_data, fifo_count, overflow, err_count};
      total_cnt++;
      if (act_v == exp_v) pass_cnt++;
      else $display("[TB] FAIL cycle_compare t=%0t: got send=%0b data=%h count=%0d ovf=%0b err=%0d, expected send=%0b data=%h count=%0d ovf=%0b err=%0d",
                    $time, act_v[22], act_v[21:14], act_v[13:9], act_v[8], act_v[7:0],
                    exp_v[22], exp_v[21:14], exp_v[13:9], exp_v[8], exp_v[7:0]);
    end
    while (lit_done != lit_seq) begin
      total_cnt++;
      if (req_act[lit_done % 64] == req_exp[lit_done % 64]) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", req_name[lit_done % 64],
                    req_act[lit_done % 64], req_exp[lit_done % 64]);
      lit_done++;
    end
    if (bus.tx_send && !prev_send) echo_log.push_back(bus.tx_data);
    prev_send = bus.tx_send;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    req_name[lit_seq % 64] = name;
    req_act[lit_seq % 64]  = act;
    req_exp[lit_seq % 64]  = exp;
    lit_seq++;
  endtask

  task automatic waitEdge(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data, input logic err);
    bus.rx_data  = data;
    bus.rx_error = err;
    bus.rx_ready = 1'b1;
    waitEdge();
    bus.rx_ready = 1'b0;
    bus.rx_error = 1'b0;
    waitEdge();
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (!(m_q.size() == 0 && !m_send && !m_wait_high) && n < 1000) begin
      waitEdge();
      n++;
    end
    checkOutput(name, 32'(n < 1000), 32'd1);
  endtask

  int mark;

  initial begin
    bus.rx_data  = '0;
    bus.rx_error = 1'b0;
    bus.rx_ready = 1'b1;
    waitEdge();
    chk_on = 1'b1;

    // Reset release with rx_ready already high
    waitEdge(2);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'h0);
    checkOutput("rst_err", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    waitEdge(3);
    checkOutput("rel_count", 32'(fifo_count), 32'd0);
    checkOutput("rel_send", 32'(bus.tx_send), 32'd0);
    bus.rx_ready = 1'b0;
    waitEdge();

    // Single echo with latency
    mark = echo_log.size();
    bus.rx_data = 8'hA5;
    bus.rx_ready = 1'b1;
    waitEdge();
    checkOutput("echo_count_k", 32'(fifo_count), 32'd1);
    checkOutput("echo_send_k", 32'(bus.tx_send), 32'd0);
    bus.rx_ready = 1'b0;
    waitEdge();
    checkOutput("echo_send_k1", 32'(bus.tx_send), 32'd1);
    checkOutput("echo_data_k1", 32'(bus.tx_data), 32'hA5);
    manual_ready = 1'b0;
    waitEdge();
    checkOutput("echo_ack", 32'(bus.tx_send), 32'd0);
    manual_ready = 1'b1;
    waitEdge(2);
    checkOutput("echo_done_count", 32'(fifo_count), 32'd0);

    // Burst of 18 with transmitter busy: last two lost
    manual_ready = 1'b0;
    mark = echo_log.size();
    for (int i = 1; i <= 18; i++) applyStimulus(DW'(i), 1'b0);
    checkOutput("burst_count", 32'(fifo_count), 32'd16);
    checkOutput("burst_ovf", 32'(overflow), 32'd1);
    agent_on = 1'b1;
    waitDrain("burst_drain_timeout");
    checkOutput("burst_echo_n", 32'(echo_log.size() - mark), 32'd16);
    for (int i = 0; i < 16 && mark + i < echo_log.size(); i++)
      checkOutput($sformatf("burst_echo_%0d", i), 32'(echo_log[mark + i]), 32'(i + 1));
    agent_on = 1'b0;
    manual_ready = 1'b1;

    // Errored bytes and saturation
    clear_status = 1'b1;
    waitEdge();
    clear_status = 1'b0;
    checkOutput("clr_ovf", 32'(overflow), 32'd0);
    mark = echo_log.size();
    for (int i = 0; i < 3; i++) applyStimulus(DW'($urandom), 1'b1);
    checkOutput("err_3", 32'(err_count), 32'd3);
    checkOutput("err_no_queue", 32'(fifo_count), 32'd0);
    waitEdge(3);
    checkOutput("err_no_echo", 32'(echo_log.size() - mark), 32'd0);
    for (int i = 0; i < 300; i++) applyStimulus(DW'($urandom), 1'b1);
    checkOutput("err_sat", 32'(err_count), 32'd255);
    clear_status = 1'b1;
    waitEdge();
    clear_status = 1'b0;
    checkOutput("err_clr", 32'(err_count), 32'd0);

    // Full FIFO with pop and push on the same edge
    manual_ready = 1'b0;
    mark = echo_log.size();
    for (int i = 0; i < 16; i++) applyStimulus(DW'(8'h20 + i), 1'b0);
    checkOutput("sim_full", 32'(fifo_count), 32'd16);
    manual_ready = 1'b1;
    bus.rx_data = 8'h30;
    bus.rx_ready = 1'b1;
    waitEdge();
    checkOutput("sim_count", 32'(fifo_count), 32'd16);
    checkOutput("sim_ovf", 32'(overflow), 32'd0);
    checkOutput("sim_data", 32'(bus.tx_data), 32'h20);
    bus.rx_ready = 1'b0;
    manual_ready = 1'b0;
    waitEdge();
    agent_on = 1'b1;
    waitDrain("sim_drain_timeout");
    checkOutput("sim_echo_n", 32'(echo_log.size() - mark), 32'd17);
    for (int i = 0; i < 17 && mark + i < echo_log.size(); i++)
      checkOutput($sformatf("sim_echo_%0d", i), 32'(echo_log[mark + i]), 32'(8'h20 + i));
    agent_on = 1'b0;

    // Reset while waiting for ack with five bytes queued
    manual_ready = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(DW'(8'h40 + i), 1'b0);
    manual_ready = 1'b1;
    waitEdge();
    checkOutput("mid_send", 32'(bus.tx_send), 32'd1);
    checkOutput("mid_count", 32'(fifo_count), 32'd5);
    waitEdge();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_send", 32'(bus.tx_send), 32'd0);
    checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
    mark = echo_log.size();
    waitEdge(2);
    rst_n = 1'b1;
    waitEdge();
    agent_on = 1'b1;
    applyStimulus(8'h77, 1'b0);
    waitDrain("mid_drain_timeout");
    checkOutput("mid_echo_n", 32'(echo_log.size() - mark), 32'd1);
    if (echo_log.size() > mark) checkOutput("mid_echo_first", 32'(echo_log[mark]), 32'h77);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.rx_ready = 1'($urandom_range(0, 1));
      bus.rx_error = ($urandom_range(0, 7) == 0);
      bus.rx_data  = DW'($urandom);
      clear_status = ($urandom_range(0, 49) == 0);
      waitEdge();
    end
    bus.rx_ready = 1'b0;
    bus.rx_error = 1'b0;
    clear_status = 1'b0;
    waitDrain("rand_drain_timeout");
    checkOutput("rand_empty", 32'(fifo_count), 32'd0);

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
